serial_paralelo_phy_rx: RTL and testbench
=========================================

# serial_paralelo_phy_rx

PHY receive front end sitting directly downstream of the PHY transmitter's serial output. It deserializes the single-bit stream on `clk_32f` into bytes, acquires byte alignment by hunting for the COM character, and declares the link active after a run of aligned COM bytes. Once active it presents each received data byte, held stable for one byte period, to the receive-side byte demux.

## Interface
Parameters:
- `COM_CHAR`, 8'hBC, alignment/idle character sent by the transmitter
- `COM_LOCK`, 4, consecutive aligned COM bytes needed to assert `active` (range 2..8)
- `IDLE_LIMIT`, 4, consecutive COM bytes in ACTIVE before `idle_out` asserts (only with `PHY_RX_IDLE_DET_EN`, range 1..15)

Ports:
- `clk_32f` input 1 — bit clock; single clock domain, all state on rising edge
- `default_values` input 1 — asynchronous, active-low reset
- `data_in` input 1 — serial bit, MSB of each byte first
- `data_out` output 8 — last received non-COM byte in ACTIVE
- `valid_out` output 1 — high while `data_out` holds a byte received in the current byte period
- `active` output 1 — link aligned and locked
- `cnt` output 3 — bit position within current byte (0..7); 7 marks the byte-completing edge
- `idle_out` output 1 — link idle (present only with `PHY_RX_IDLE_DET_EN`)

## Operation
- Shift register: every edge `sh <= {sh[6:0], data_in}`; `byte_nx = {sh[6:0], data_in}` is the byte completed at the current edge.
- States SEARCH, ALIGN, ACTIVE; reset enters SEARCH.
- SEARCH: every edge compare `byte_nx` to `COM_CHAR`. On match: `cnt <= 0`, `com_cnt <= 1`, go ALIGN. Else `cnt` frozen at 0.
- ALIGN: `cnt` increments mod 8. On edge with `cnt == 7`: `byte_nx == COM_CHAR` → `com_cnt++`; when the increment reaches `COM_LOCK`, go ACTIVE and set `active` on that same edge. `byte_nx != COM_CHAR` → `com_cnt <= 0`, go SEARCH.
- ACTIVE: `cnt` increments mod 8. On edge with `cnt == 7`: non-COM byte → `data_out <= byte_nx`, `valid_out <= 1`; COM byte → `valid_out <= 0`, `data_out` holds previous value.
- ACTIVE is left only by reset; no lock-loss detection.
- `com_cnt` saturates at `COM_LOCK`; width `$clog2(COM_LOCK+1)`.

## Timing
- Reset values: `data_out` 8'h00, `valid_out` 0, `active` 0, `cnt` 0, `idle_out` 0, `sh` 0, state SEARCH.
- Reset is asynchronous; assertion mid-byte clears everything immediately; realignment restarts from SEARCH after release.
- `data_out`/`valid_out` update only on `cnt == 7` edges and hold for exactly 8 `clk_32f` cycles (one `clk_4f` period).
- Latency: last bit of a byte sampled at edge N → `data_out` valid after edge N.
- First COM detected at edge N → `active` after edge N + 8·(`COM_LOCK`−1).
- First data byte after lock appears no earlier than the byte period following the `active` edge.
- A COM pattern straddling byte boundaries in ALIGN/ACTIVE is ignored; only aligned bytes are compared.

## Configuration
- `PHY_RX_IDLE_DET_EN` defined: `idle_out` port and 4-bit `idle_cnt` exist. In ACTIVE, each aligned COM byte increments `idle_cnt` (saturating at `IDLE_LIMIT`); `idle_out` set on the edge it reaches `IDLE_LIMIT`. Any non-COM byte clears `idle_cnt` and `idle_out` on its `cnt == 7` edge. In SEARCH/ALIGN `idle_out` = 0.
- Not defined: no `idle_out` port, no idle counter; all other behaviour identical.

## Test plan
- Reset then 4× 8'hBC, MSB first, starting at cycle 3 → `active` rises after the edge sampling bit 7 of the 4th BC (cycle 3+31); `valid_out` stays 0.
- Lock, then send 8'hA5, 8'h3C → `data_out`=A5 with `valid_out`=1 for 8 cycles, then 3C for 8 cycles; `cnt` wraps 7→0 on each boundary.
- Lock, then A5, BC, BC → `valid_out` drops to 0 at the BC boundary, `data_out` holds A5; with macro and `IDLE_LIMIT`=2, `idle_out` rises on the second BC boundary and clears on next non-BC byte.
- 3 random bits then BC, BC, 8'h11 → ALIGN aborts at 8'h11 (`com_cnt` 0, state SEARCH, `active` 0); subsequent 4× BC locks normally.
- Stream 8'h5E,8'h2F (BC straddling, bits …10111100…) while SEARCH → bit-level match realigns `cnt` to the straddled position.
- Assert `default_values`=0 mid-byte in ACTIVE → all outputs return to reset values asynchronously; after release, 4× BC relocks.

Source files
------------

// File: rtl/serial_paralelo_phy_rx.sv
// Serial-to-parallel PHY receiver: COM-based byte alignment, lock after COM_LOCK aligned COMs.
// Optional idle detection is built when PHY_RX_IDLE_DET_EN is defined.
module serial_paralelo_phy_rx #(
  parameter logic [7:0]  COM_CHAR   = 8'hBC,
  parameter int unsigned COM_LOCK   = 4,
  parameter int unsigned IDLE_LIMIT = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
`ifdef PHY_RX_IDLE_DET_EN
  output logic       idle_out,
`endif
  output logic [2:0] cnt
);

  localparam int unsigned CW = $clog2(COM_LOCK + 1);

  if (COM_LOCK < 2 || COM_LOCK > 8) begin : g_bad_com_lock
    $error("COM_LOCK out of range 2..8");
  end
  if (IDLE_LIMIT < 1 || IDLE_LIMIT > 15) begin : g_bad_idle_limit
    $error("IDLE_LIMIT out of range 1..15");
  end

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  state_t        r_state, w_state_nx;
  logic [6:0]    r_sh;
  logic [7:0]    w_byte_nx;
  logic [2:0]    r_cnt, w_cnt_nx;
  logic [CW-1:0] r_com_cnt, w_com_cnt_nx;
  logic [7:0]    r_data, w_data_nx;
  logic          r_valid, w_valid_nx;
  logic          r_active, w_active_nx;
  logic          w_is_com;
  logic          w_boundary;
`ifdef PHY_RX_IDLE_DET_EN
  logic [3:0]    r_idle_cnt, w_idle_cnt_nx;
  logic          r_idle, w_idle_nx;
`endif

  assign w_byte_nx  = {r_sh, data_in};
  assign w_is_com   = (w_byte_nx == COM_CHAR);
  assign w_boundary = (r_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge default_values) begin
    if (!default_values) begin
      r_state    <= SEARCH;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_com_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
`ifdef PHY_RX_IDLE_DET_EN
      r_idle_cnt <= '0;
      r_idle     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_sh       <= w_byte_nx[6:0];
      r_cnt      <= w_cnt_nx;
      r_com_cnt  <= w_com_cnt_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
      r_active   <= w_active_nx;
`ifdef PHY_RX_IDLE_DET_EN
      r_idle_cnt <= w_idle_cnt_nx;
      r_idle     <= w_idle_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt + 3'd1;
    w_com_cnt_nx = r_com_cnt;
    w_data_nx    = r_data;
    w_valid_nx   = r_valid;
    w_active_nx  = r_active;
`ifdef PHY_RX_IDLE_DET_EN
    w_idle_cnt_nx = r_idle_cnt;
    w_idle_nx     = r_idle;
`endif
    case (r_state)
      SEARCH: begin
        // Bit-level hunt: any 8-bit window equal to COM sets the byte phase.
        w_cnt_nx = 3'd0;
        if (w_is_com) begin
          w_state_nx   = ALIGN;
          w_com_cnt_nx = CW'(1);
        end
      end
      ALIGN: begin
        if (w_boundary) begin
          if (w_is_com) begin
            if (r_com_cnt == CW'(COM_LOCK - 1)) begin
              w_com_cnt_nx = CW'(COM_LOCK);
              w_state_nx   = ACTIVE;
              w_active_nx  = 1'b1;
            end else begin
              w_com_cnt_nx = r_com_cnt + 1'b1;
            end
          end else begin
            w_com_cnt_nx = '0;
            w_state_nx   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (w_boundary) begin
          if (w_is_com) begin
            w_valid_nx = 1'b0;
`ifdef PHY_RX_IDLE_DET_EN
            if (r_idle_cnt != 4'(IDLE_LIMIT)) begin
              w_idle_cnt_nx = r_idle_cnt + 4'd1;
            end
            if (r_idle_cnt == 4'(IDLE_LIMIT - 1)) begin
              w_idle_nx = 1'b1;
            end
`endif
          end else begin
            w_data_nx  = w_byte_nx;
            w_valid_nx = 1'b1;
`ifdef PHY_RX_IDLE_DET_EN
            w_idle_cnt_nx = '0;
            w_idle_nx     = 1'b0;
`endif
          end
        end
      end
      default: w_state_nx = SEARCH;
    endcase
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = r_active;
  assign cnt       = r_cnt;
`ifdef PHY_RX_IDLE_DET_EN
  assign idle_out  = r_idle;
`endif

endmodule

// File: tb/tb_serial_paralelo_phy_rx.sv
// Bench for serial_paralelo_phy_rx: directed + random bit streams against a bit-index reference model.
module tb_serial_paralelo_phy_rx;
`ifdef PHY_RX_IDLE_DET_EN
  localparam int IL = 2;
`else
  localparam int IL = 4;
`endif
  localparam int LOCK = 4;
  localparam logic [7:0] COM = 8'hBC;

  logic       clk = 1'b0;
  logic       rstn;
  logic       din;
  logic [7:0] dout;
  logic       vld;
  logic       act;
  logic [2:0] cnt;
`ifdef PHY_RX_IDLE_DET_EN
  logic       idle;
`endif

  always #5 clk = ~clk;

  serial_paralelo_phy_rx #(.COM_CHAR(COM), .COM_LOCK(LOCK), .IDLE_LIMIT(IL)) dut (
    .clk_32f       (clk),
    .default_values(rstn),
    .data_in       (din),
    .data_out      (dout),
    .valid_out     (vld),
    .active        (act),
`ifdef PHY_RX_IDLE_DET_EN
    .idle_out      (idle),
`endif
    .cnt           (cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bit index since reset, index of the last COM hit, mode 0/1/2.
  int         m_t, m_anchor, m_mode, m_ncom, m_win, m_idle_cnt, m_cnt;
  logic [7:0] m_data;
  logic       m_valid, m_active, m_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_anchor = 0; m_mode = 0; m_ncom = 0; m_win = 0; m_idle_cnt = 0; m_cnt = 0;
    m_data = 8'h00; m_valid = 1'b0; m_active = 1'b0; m_idle = 1'b0;
  endtask

  task automatic model_step(input logic b);
    m_win = ((m_win << 1) | int'(b)) & 255;
    if (m_mode == 0) begin
      if (m_win == int'(COM)) begin
        m_anchor = m_t; m_ncom = 1; m_mode = 1;
      end
    end else if ((m_t - m_anchor) % 8 == 0) begin
      if (m_mode == 1) begin
        if (m_win == int'(COM)) begin
          m_ncom++;
          if (m_ncom == LOCK) begin m_mode = 2; m_active = 1'b1; end
        end else begin
          m_ncom = 0; m_mode = 0;
        end
      end else begin
        if (m_win != int'(COM)) begin
          m_data = 8'(m_win); m_valid = 1'b1; m_idle_cnt = 0; m_idle = 1'b0;
        end else begin
          m_valid = 1'b0;
          if (m_idle_cnt < IL) m_idle_cnt++;
          if (m_idle_cnt == IL) m_idle = 1'b1;
        end
      end
    end
    m_cnt = (m_mode == 0) ? 0 : (m_t - m_anchor) % 8;
    m_t++;
  endtask

  task automatic compare_all();
    check("cnt", 32'(cnt), 32'(m_cnt));
    check("active", 32'(act), 32'(m_active));
    check("valid_out", 32'(vld), 32'(m_valid));
    check("data_out", 32'(dout), 32'(m_data));
`ifdef PHY_RX_IDLE_DET_EN
    check("idle_out", 32'(idle), 32'(m_idle));
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(dout), 32'h0);
    check({tag, "_valid"}, 32'(vld), 32'h0);
    check({tag, "_active"}, 32'(act), 32'h0);
    check({tag, "_cnt"}, 32'(cnt), 32'h0);
`ifdef PHY_RX_IDLE_DET_EN
    check({tag, "_idle"}, 32'(idle), 32'h0);
`endif
  endtask

  task automatic send_bit(input logic b);
    din = b;
    @(posedge clk);
    model_step(b);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_random_bytes(input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom_range(0, 255));
      send_byte(r);
    end
  endtask

  task automatic send_random_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  // Called just after a rising edge; pulls reset between edges and checks it took effect at once.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    @(posedge clk);
    #1;
    check_reset_values({tag, "_held"});
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    din  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rstn = 1'b1;

    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 0; i < LOCK; i++) send_byte(COM);
    check("lock_active", 32'(act), 32'h1);
    check("lock_valid", 32'(vld), 32'h0);

    send_byte(8'hA5);
    check("first_byte", 32'(dout), 32'hA5);
    send_byte(8'h3C);
    check("second_byte", 32'(dout), 32'h3C);

    send_byte(8'hA5);
    send_byte(COM);
    check("com_hold_data", 32'(dout), 32'hA5);
    check("com_drop_valid", 32'(vld), 32'h0);
    send_byte(COM);
    send_random_bytes(16);

    send_random_bits(3);
    async_reset("midbyte_rst");

    send_random_bits(3);
    send_byte(COM);
    send_byte(COM);
    send_byte(8'h11);
    send_random_bits(5);
    for (int i = 0; i < LOCK; i++) send_byte(COM);
    send_random_bytes(8);

    async_reset("straddle_rst");
    send_byte(8'h5E);
    send_byte(8'h2F);
    send_random_bits(7);
    for (int i = 0; i < LOCK; i++) send_byte(COM);
    send_random_bytes(6);

    async_reset("garbage_rst");
    send_random_bits(64);
    for (int i = 0; i < LOCK + 1; i++) send_byte(COM);
    send_random_bytes(24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
